alu_sequencer: RTL
==================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
Parameters:
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning operand/result width.
REQ-002 The block SHALL have parameter SHAMT_W, default 5, meaning shift-amount width.

Ports:
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port cmd_valid, input, 1 bit: command offered.
REQ-006 The block SHALL have port cmd_ready, output, 1 bit: command accepted this cycle when high with cmd_valid.
REQ-007 The block SHALL have ports cmd_aluop (input, 2), cmd_func (input, 6), cmd_a (input, DATA_W), cmd_b (input, DATA_W) and cmd_shamt (input, SHAMT_W): command fields.
REQ-008 The block SHALL have ports alu_aluop (output, 2), alu_func (output, 6), alu_ina (output, DATA_W), alu_inb (output, DATA_W) and alu_shamt (output, SHAMT_W): drive to the external ALU_Control/ALU pair.
REQ-009 The block SHALL have ports alu_out (input, DATA_W), alu_cr, alu_ov, alu_ng and alu_zr (inputs, 1 each): combinational ALU return.
REQ-010 The block SHALL have port rsp_valid, output, 1 bit: result available.
REQ-011 The block SHALL have port rsp_ready, input, 1 bit: consumer takes result.
REQ-012 The block SHALL have ports rsp_data (output, DATA_W) and rsp_flags (output, 4 bits, order {cr,ov,ng,zr}): captured result and flags.
REQ-013 The block SHALL have port op_count, output, 8 bits: number of completed responses, wraps 255->0.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE, CAPTURE and RESP.
REQ-015 cmd_ready SHALL be 1 only in IDLE, and the IDLE->ISSUE transition SHALL occur on cmd_valid&cmd_ready, latching all cmd_* fields into operand registers.
REQ-016 alu_* outputs SHALL be driven only from the operand registers, never combinationally from cmd_*, and SHALL hold stable from ISSUE through CAPTURE.
REQ-017 ISSUE SHALL last exactly one cycle (ALU settle) and SHALL go to CAPTURE.
REQ-018 In CAPTURE, rsp_data and rsp_flags SHALL be registered from the alu_* inputs, and the state SHALL go to RESP.
REQ-019 rsp_valid SHALL be 1 only in RESP, rising exactly 3 cycles after the accepting edge.
REQ-020 In RESP, rsp_data and rsp_flags SHALL hold stable until rsp_valid&rsp_ready.
REQ-021 On rsp_valid&rsp_ready the block SHALL go to IDLE and op_count SHALL increment by 1 modulo 256.
REQ-022 Back-to-back throughput SHALL be one command per 4 cycles, or more with response backpressure.
REQ-023 cmd_valid while not in IDLE SHALL be ignored, and cmd_* SHALL NOT be sampled.
REQ-024 rsp_ready while not in RESP SHALL have no effect.
REQ-025 When not in ISSUE/CAPTURE, alu_* outputs SHALL retain their last operand register values.

Reset
REQ-026 On rst=1 at a clock edge: state SHALL be IDLE, cmd_ready=1 after reset deassertion, rsp_valid=0, rsp_data=0, rsp_flags=0, op_count=0, and all operand registers (hence alu_*) SHALL be 0.
REQ-027 rst SHALL dominate any handshake in the same cycle, and an in-flight command (ISSUE/CAPTURE/RESP) SHALL be discarded without a response or op_count increment.

Configuration
REQ-028 With macro ALU_SEQ_STICKY_FLAGS_EN defined, the block SHALL add 4-bit output sticky_flags, which ORs rsp_flags at every CAPTURE and is cleared only by rst.
REQ-029 Without ALU_SEQ_STICKY_FLAGS_EN, the sticky_flags port and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-030 The bench SHALL cover: ADD, aluop=10 func=000000 a=10 b=20 -> rsp_valid 3 cycles after accept, rsp_data=0x1E, flags=0000, op_count=1.
REQ-031 The bench SHALL cover: aluop=00 a=0x81 b=0x99 -> rsp_data=0x1A, cr=1, ov=1, ng=0, zr=0.
REQ-032 The bench SHALL cover: aluop=01 a=0x99 b=0x81 -> rsp_data=0x18, cr/ov per ALU, then a=0x81 b=0x99 -> rsp_data=0xE8, ng=1.
REQ-033 The bench SHALL cover: rsp_ready held 0 for 5 cycles in RESP -> rsp_valid/rsp_data stable, cmd_ready=0, a new cmd_valid ignored, op_count unchanged until the handshake.
REQ-034 The bench SHALL cover: rst asserted in CAPTURE -> next cycle IDLE, rsp_valid=0, op_count=0, alu_ina=0, and no response emitted.
REQ-035 The bench SHALL cover: 256 consecutive completed commands -> op_count wraps to 0; with ALU_SEQ_STICKY_FLAGS_EN, sticky_flags[3]=1 after the 0x81+0x99 case and stays 1 until rst.

Source files
------------

// File: rtl/alu_sequencer.sv
// Sequences one command through an external combinational ALU; ALU_SEQ_STICKY_FLAGS_EN adds sticky_flags.
// Latency: rsp_valid rises three cycles after the command cycle; 1 cmd / 4 cycles, RESP holds until rsp_ready.
module alu_sequencer #(
  parameter int DATA_W  = 8,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_aluop,
  input  logic [5:0]         cmd_func,
  input  logic [DATA_W-1:0]  cmd_a,
  input  logic [DATA_W-1:0]  cmd_b,
  input  logic [SHAMT_W-1:0] cmd_shamt,
  output logic [1:0]         alu_aluop,
  output logic [5:0]         alu_func,
  output logic [DATA_W-1:0]  alu_ina,
  output logic [DATA_W-1:0]  alu_inb,
  output logic [SHAMT_W-1:0] alu_shamt,
  input  logic [DATA_W-1:0]  alu_out,
  input  logic               alu_cr,
  input  logic               alu_ov,
  input  logic               alu_ng,
  input  logic               alu_zr,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_data,
  output logic [3:0]         rsp_flags,
  output logic [7:0]         op_count
`ifdef ALU_SEQ_STICKY_FLAGS_EN
  ,
  output logic [3:0]         sticky_flags
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t state;

  // The alu_* outputs are the operand registers themselves, so they only move on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_flags <= '0;
      op_count  <= '0;
      alu_aluop <= '0;
      alu_func  <= '0;
      alu_ina   <= '0;
      alu_inb   <= '0;
      alu_shamt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            alu_aluop <= cmd_aluop;
            alu_func  <= cmd_func;
            alu_ina   <= cmd_a;
            alu_inb   <= cmd_b;
            alu_shamt <= cmd_shamt;
            cmd_ready <= 1'b0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          rsp_data  <= alu_out;
          rsp_flags <= {alu_cr, alu_ov, alu_ng, alu_zr};
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            op_count  <= op_count + 8'd1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_STICKY_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_flags <= '0;
    end else if (state == CAPTURE) begin
      sticky_flags <= sticky_flags | {alu_cr, alu_ov, alu_ng, alu_zr};
    end
  end
`endif

endmodule
